// File: rtl/fabric_cfg_pkg.sv
// Shared types and helpers for the fabric configuration sequencer: FSM states,
// the registered status bundle and counter sizing functions.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SHIFT,
        ST_RELEASE,
        ST_DONE
    } cfg_state_t;

    typedef struct packed {
        logic fabric_reset;
        logic fabric_clk_en;
        logic busy;
        logic done;
    } cfg_status_t;

    localparam int unsigned DEF_CHAIN_LEN  = 1024;
    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_RST_CYCLES = 4;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    // Number of live bits in the final bitstream word.
    function automatic int unsigned tail_bits(input int unsigned chain_len,
                                              input int unsigned word_w);
        int unsigned r;
        r = chain_len % word_w;
        return (r == 0) ? word_w : r;
    endfunction

    localparam int unsigned DEF_BIT_CNT_W = cnt_w(DEF_CHAIN_LEN);
    localparam int unsigned DEF_LEN_W     = cnt_w(DEF_WORD_W);

    function automatic cfg_status_t status_of(input cfg_state_t s);
        cfg_status_t st;
        st = '{fabric_reset: 1'b1, fabric_clk_en: 1'b0, busy: 1'b0, done: 1'b0};
        case (s)
            ST_RST, ST_SHIFT: st.busy = 1'b1;
            ST_RELEASE: begin
                st.busy         = 1'b1;
                st.fabric_reset = 1'b0;
            end
            ST_DONE: begin
                st.fabric_reset  = 1'b0;
                st.fabric_clk_en = 1'b1;
                st.done          = 1'b1;
            end
            default: ;
        endcase
        return st;
    endfunction

    localparam cfg_status_t RST_STATUS = status_of(ST_IDLE);

endpackage

// File: rtl/cfg_word_serializer.sv
// Word-to-bit PISO: a load presents bit 0 on the next cycle and queues the
// remaining len-1 bits, which then drain one per clock.
module cfg_word_serializer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    output logic              head,
    output logic              head_vld,
    output logic              empty,
    output logic              empty_nxt
);

    logic [WORD_W-1:0] sreg, sreg_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic              head_nxt, vld_nxt;

    // rem counts bits still waiting behind the one currently on head
    assign empty     = (rem == '0);
    assign empty_nxt = (rem_nxt == '0);

    always_comb begin
        sreg_nxt = sreg;
        rem_nxt  = rem;
        head_nxt = head;
        vld_nxt  = 1'b0;
        if (load) begin
            head_nxt = data[0];
            sreg_nxt = data >> 1;
            rem_nxt  = len - LEN_W'(1);
            vld_nxt  = 1'b1;
        end else if (!empty) begin
            head_nxt = sreg[0];
            sreg_nxt = sreg >> 1;
            rem_nxt  = rem - LEN_W'(1);
            vld_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg     <= '0;
            rem      <= '0;
            head     <= 1'b0;
            head_vld <= 1'b0;
        end else begin
            sreg     <= sreg_nxt;
            rem      <= rem_nxt;
            head     <= head_nxt;
            head_vld <= vld_nxt;
        end
    end

endmodule

// File: rtl/fabric_cfg_sequencer.sv
// Power-up sequencer for the fabric: hold global reset, stream the bitstream
// into the configuration chain, then release reset and enable the user clock.
module fabric_cfg_sequencer
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              ccff_head,
    output logic              prog_en,
    output logic              fabric_reset,
    output logic              fabric_set,
    output logic              fabric_clk_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned BIT_CNT_W = cnt_w(CHAIN_LEN);
    localparam int unsigned WRD_CNT_W = cnt_w(NUM_WORDS);
    localparam int unsigned RST_CNT_W = cnt_w(RST_CYCLES);
    localparam int unsigned LEN_W     = cnt_w(WORD_W);

    localparam logic [BIT_CNT_W-1:0] BITS_ALL   = BIT_CNT_W'(CHAIN_LEN);
    localparam logic [WRD_CNT_W-1:0] WORDS_ALL  = WRD_CNT_W'(NUM_WORDS);
    localparam logic [WRD_CNT_W-1:0] WORDS_LAST = WRD_CNT_W'(NUM_WORDS - 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST   = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [LEN_W-1:0]     LEN_FULL   = LEN_W'(WORD_W);
    localparam logic [LEN_W-1:0]     LEN_TAIL   = LEN_W'(tail_bits(CHAIN_LEN, WORD_W));

    cfg_state_t             state, state_nxt;
    cfg_status_t            status_q;
    logic [RST_CNT_W-1:0]   rst_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [WRD_CNT_W-1:0]   word_cnt, word_cnt_nxt;
    logic [LEN_W-1:0]       ser_len;
    logic                   load, bit_inc, ser_empty, ser_empty_nxt;
    logic                   in_ready_nxt, set_q;

    assign load    = in_valid && in_ready;
    assign bit_inc = load || !ser_empty;
    // Only the final word can be short; its upper bits never reach the chain.
    assign ser_len = (word_cnt == WORDS_LAST) ? LEN_TAIL : LEN_FULL;

    assign word_cnt_nxt = (state == ST_RST) ? '0 : word_cnt + WRD_CNT_W'(load);

    // Ready is registered, so it is derived from next-cycle serializer state;
    // rising while the last bit drains is what makes words back-to-back.
    assign in_ready_nxt = (state_nxt == ST_SHIFT) && ser_empty_nxt &&
                          (word_cnt_nxt != WORDS_ALL);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_RST;
            ST_RST:           if (rst_cnt == RST_LAST) state_nxt = ST_SHIFT;
            ST_SHIFT:         if (bit_cnt == BITS_ALL) state_nxt = ST_RELEASE;
            ST_RELEASE:       state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            status_q <= RST_STATUS;
            rst_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            in_ready <= 1'b0;
            set_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            status_q <= status_of(state_nxt);
            rst_cnt  <= (state == ST_RST) ? rst_cnt + RST_CNT_W'(1) : '0;
            bit_cnt  <= (state == ST_RST) ? '0 : bit_cnt + BIT_CNT_W'(bit_inc);
            word_cnt <= word_cnt_nxt;
            in_ready <= in_ready_nxt;
            set_q    <= 1'b0;
        end
    end

    cfg_word_serializer #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .data      (in_data),
        .len       (ser_len),
        .head      (ccff_head),
        .head_vld  (prog_en),
        .empty     (ser_empty),
        .empty_nxt (ser_empty_nxt)
    );

    assign fabric_reset  = status_q.fabric_reset;
    assign fabric_clk_en = status_q.fabric_clk_en;
    assign busy          = status_q.busy;
    assign done          = status_q.done;
    assign fabric_set    = set_q;

endmodule

// File: tb/tb_fabric_cfg_sequencer.sv
// Directed bench: a queue-based model of the power-up sequence is checked
// every cycle against a 10-bit chain, plus a direct run on an 8-bit chain.
module tb_fabric_cfg_sequencer;

    localparam int CL = 10, WW = 4, RC = 4, NW = 3, TAIL = 2;
    localparam int P_IDLE = 0, P_RST = 1, P_SHIFT = 2, P_REL = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic          start_a = 0, in_valid_a = 0;
    logic [WW-1:0] in_data_a = '0;
    logic in_ready_a, ccff_head_a, prog_en_a, fabric_reset_a, fabric_set_a;
    logic fabric_clk_en_a, busy_a, done_a;

    logic          start_b = 0, in_valid_b = 0;
    logic [3:0]    in_data_b = '0;
    logic in_ready_b, ccff_head_b, prog_en_b, fabric_reset_b, fabric_set_b;
    logic fabric_clk_en_b, busy_b, done_b;

    fabric_cfg_sequencer #(.CHAIN_LEN(CL), .WORD_W(WW), .RST_CYCLES(RC)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_data(in_data_a), .ccff_head(ccff_head_a),
        .prog_en(prog_en_a), .fabric_reset(fabric_reset_a), .fabric_set(fabric_set_a),
        .fabric_clk_en(fabric_clk_en_a), .busy(busy_a), .done(done_a));

    fabric_cfg_sequencer #(.CHAIN_LEN(8), .WORD_W(4), .RST_CYCLES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_data(in_data_b), .ccff_head(ccff_head_b),
        .prog_en(prog_en_b), .fabric_reset(fabric_reset_b), .fabric_set(fabric_set_b),
        .fabric_clk_en(fabric_clk_en_b), .busy(busy_b), .done(done_b));

    initial forever #5 clk = ~clk;

    int total = 0, bad = 0;

    // model of DUT A: phase, pending bits of the current word, counts
    int m_phase, m_rst_left, m_words, m_pulses;
    bit m_q[$];
    bit m_hs;
    bit e_ready, e_pen, e_head, e_busy, e_done, e_frst, e_clken;

    logic [WW-1:0] wlist [NW] = '{4'hA, 4'h5, 4'hF};
    int widx, k, pcnt, first_k, last_k, done_k, rdy_k;
    logic [15:0] seq_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_q.delete(); m_words = 0; m_pulses = 0; m_hs = 0;
        e_ready = 0; e_pen = 0; e_head = 0; e_busy = 0; e_done = 0;
        e_frst = 1; e_clken = 0;
    endtask

    task automatic model_step();
        int n;
        m_hs  = e_ready && in_valid_a;
        e_pen = 0;
        case (m_phase)
            P_IDLE, P_DONE: if (start_a) begin
                m_phase = P_RST; m_rst_left = RC; m_words = 0; m_pulses = 0; m_q.delete();
            end
            P_RST: begin
                m_rst_left--;
                if (m_rst_left == 0) m_phase = P_SHIFT;
            end
            P_SHIFT: begin
                if (m_pulses == CL) m_phase = P_REL;
                else if (m_hs) begin
                    n = (m_words == NW - 1) ? TAIL : WW;
                    e_head = in_data_a[0];
                    for (int i = 1; i < n; i++) m_q.push_back(in_data_a[i]);
                    e_pen = 1; m_pulses++; m_words++;
                end else if (m_q.size() > 0) begin
                    e_head = m_q.pop_front();
                    e_pen = 1; m_pulses++;
                end
            end
            default: m_phase = P_DONE;
        endcase
        e_ready = (m_phase == P_SHIFT) && (m_q.size() == 0) && (m_words < NW);
        e_busy  = (m_phase == P_RST) || (m_phase == P_SHIFT) || (m_phase == P_REL);
        e_done  = (m_phase == P_DONE);
        e_clken = (m_phase == P_DONE);
        e_frst  = !((m_phase == P_REL) || (m_phase == P_DONE));
    endtask

    task automatic compare();
        if (prog_en_a) begin
            if (pcnt < 16) seq_a[pcnt] = ccff_head_a;
            if (first_k < 0) first_k = k;
            last_k = k;
            pcnt++;
        end
        if (done_a && done_k < 0) done_k = k;
        if (in_ready_a && rdy_k < 0) rdy_k = k;
        chk("in_ready", in_ready_a, e_ready);
        chk("prog_en", prog_en_a, e_pen);
        chk("ccff_head", ccff_head_a, e_head);
        chk("fabric_reset", fabric_reset_a, e_frst);
        chk("fabric_set", fabric_set_a, 0);
        chk("fabric_clk_en", fabric_clk_en_a, e_clken);
        chk("busy", busy_a, e_busy);
        chk("done", done_a, e_done);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            model_step();
            if (m_hs) widx++;
        end
        k++;
        @(negedge clk);
        compare();
    endtask

    task automatic run_load(input int gap_len, input bit mid_start, input int rst_at);
        int gap_left;
        bit mid_done;
        widx = 0; pcnt = 0; seq_a = '0; first_k = -1; last_k = -1; done_k = -1; rdy_k = -1; k = 0;
        gap_left = gap_len; mid_done = 0;
        start_a = 1; in_valid_a = 0; in_data_a = wlist[0];
        cycle();
        start_a = 0;
        chk("start_busy", busy_a, 1);
        chk("start_done", done_a, 0);
        chk("start_frst", fabric_reset_a, 1);
        chk("start_clken", fabric_clk_en_a, 0);
        for (int i = 0; i < 200; i++) begin
            if (m_phase == P_DONE) break;
            in_data_a = (widx < NW) ? wlist[widx] : '0;
            if (e_ready && widx == 1 && gap_left > 0) begin
                in_valid_a = 0; gap_left--;
            end else in_valid_a = 1;
            if (mid_start && !mid_done && m_pulses == 3) begin
                start_a = 1; mid_done = 1;
            end
            if (rst_at > 0 && m_pulses == rst_at) begin
                reset_n = 0;
                model_reset();
                #1;
                compare();
                chk("mid_rst_pen", prog_en_a, 0);
                chk("mid_rst_frst", fabric_reset_a, 1);
                chk("mid_rst_busy", busy_a, 0);
                cycle();
                reset_n = 1;
                in_valid_a = 0;
                return;
            end
            cycle();
            start_a = 0;
        end
        in_valid_a = 0;
        chk("done_seen", done_k >= 0, 1);
    endtask

    int hs_b, pulses_b, ready_after;
    bit hs_now, done_b_seen;
    logic [7:0] seq_b;

    initial begin
        model_reset();
        widx = 0; pcnt = 0; seq_a = '0; first_k = -1; last_k = -1; done_k = -1; rdy_k = -1; k = 0;
        #1 reset_n = 0;
        in_valid_a = 1;
        repeat (3) cycle();
        reset_n = 1;
        repeat (2) cycle();
        chk("rv_fabric_reset", fabric_reset_a, 1);
        chk("rv_in_ready", in_ready_a, 0);
        chk("rv_busy", busy_a, 0);
        chk("rv_prog_en", prog_en_a, 0);
        in_valid_a = 0;

        // plain load, in_valid always high
        run_load(0, 0, 0);
        chk("l1_pulses", pcnt, 10);
        chk("l1_seq", seq_a, 16'h035A);
        chk("l1_first_ready", rdy_k, 5);
        chk("l1_done_lat", done_k - last_k, 2);
        chk("l1_span", last_k - first_k, 9);
        repeat (3) cycle();
        chk("l1_done_hold", done_a, 1);

        // 3-cycle valid gap after first word (also a start from DONE)
        run_load(3, 0, 0);
        chk("l2_pulses", pcnt, 10);
        chk("l2_seq", seq_a, 16'h035A);
        chk("l2_span", last_k - first_k, 12);

        // start during SHIFT is ignored
        run_load(0, 1, 0);
        chk("l3_pulses", pcnt, 10);
        chk("l3_seq", seq_a, 16'h035A);

        // reset_n mid-shift, then a full reload
        run_load(0, 0, 5);
        chk("l4_pulses_before_rst", pcnt, 5);
        chk("l4_done", done_a, 0);
        chk("l4_frst", fabric_reset_a, 1);
        cycle();
        run_load(0, 0, 0);
        chk("l5_pulses", pcnt, 10);
        chk("l5_seq", seq_a, 16'h035A);

        // exact-multiple chain on the second instance
        hs_b = 0; pulses_b = 0; ready_after = 0; done_b_seen = 0; seq_b = '0;
        start_b = 1;
        cycle();
        start_b = 0;
        in_valid_b = 1;
        for (int i = 0; i < 60; i++) begin
            in_data_b = (hs_b == 0) ? 4'h3 : 4'hC;
            hs_now = in_ready_b && in_valid_b;
            cycle();
            if (hs_now) hs_b++;
            if (prog_en_b) begin
                if (pulses_b < 8) seq_b[pulses_b] = ccff_head_b;
                pulses_b++;
            end
            if (hs_b == 2 && in_ready_b) ready_after++;
            if (done_b) begin
                done_b_seen = 1;
                break;
            end
        end
        in_valid_b = 0;
        chk("b_handshakes", hs_b, 2);
        chk("b_pulses", pulses_b, 8);
        chk("b_seq", seq_b, 8'hC3);
        chk("b_ready_after_last", ready_after, 0);
        chk("b_done", done_b_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
